// File: rtl/stall_pipe_pkg.sv
// ============================================================================
// Module : stall_pipe_pkg
// Brief  : Shared defaults, stage record type and width helper for stall_pipe_arb.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package stall_pipe_pkg;

    localparam int c_DEF_DATA_W    = 32;
    localparam int c_DEF_STAGES    = 2;
    localparam int c_DEF_BUF_DEPTH = 4;
    localparam int c_DEF_RESP_LAT  = 1;

    // Stage record at the default data width.
    typedef struct packed {
        logic                    valid;
        logic [c_DEF_DATA_W-1:0] data;
    } stage_rec_t;

    // Bits needed to hold a count of 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stall_pipe_fifo.sv
// ============================================================================
// Module : stall_pipe_fifo
// Brief  : BUF_DEPTH x DATA_W FIFO with push/pop/flush, count and full/empty.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stall_pipe_fifo
    import stall_pipe_pkg::*;
#(
    parameter int DATA_W    = c_DEF_DATA_W,
    parameter int BUF_DEPTH = c_DEF_BUF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [DATA_W-1:0]            i_data,
    input  logic                         i_pop,
    output logic [DATA_W-1:0]            o_head,
    output logic [occ_w(BUF_DEPTH)-1:0]  o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int                 c_PTR_W = $clog2(BUF_DEPTH);
    localparam int                 c_CNT_W = occ_w(BUF_DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(BUF_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(BUF_DEPTH);

    logic [DATA_W-1:0]  r_mem [BUF_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_FULL);
    assign o_count = r_count;
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/stall_pipe_arb.sv
// ============================================================================
// Module : stall_pipe_arb
// Brief  : Globally stalled pipeline + output FIFO feeding a req/grant resource.
//          Define STALL_PIPE_STATS_EN to add the stall_cycles counter output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stall_pipe_arb
    import stall_pipe_pkg::*;
#(
    parameter int DATA_W    = c_DEF_DATA_W,
    parameter int STAGES    = c_DEF_STAGES,
    parameter int BUF_DEPTH = c_DEF_BUF_DEPTH,
    parameter int RESP_LAT  = c_DEF_RESP_LAT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            inputs,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    input  logic                         arbiter_grant,
    input  logic [DATA_W-1:0]            resource_output,
    output logic                         arbiter_req,
    output logic [DATA_W-1:0]            resource_input,
    output logic [DATA_W-1:0]            outputs,
    output logic                         out_valid,
    output logic                         stall_signal,
`ifdef STALL_PIPE_STATS_EN
    output logic [31:0]                  stall_cycles,
    output logic [occ_w(BUF_DEPTH)-1:0]  occupancy
`else
    output logic [occ_w(BUF_DEPTH)-1:0]  occupancy
`endif
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } stage_t;

    stage_t r_stage [STAGES];
    logic   w_full;
    logic   w_empty;
    logic   w_pop;
    logic   w_push;
    logic   w_resp_in;

    // A pop in the same cycle frees the slot, so a full buffer need not stall.
    assign w_pop        = arbiter_req & arbiter_grant;
    assign stall_signal = w_full & ~w_pop;
    assign in_ready     = ~stall_signal;
    assign w_push       = r_stage[STAGES-1].valid & ~stall_signal;
    assign arbiter_req  = ~w_empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int k = 0; k < STAGES; k++) r_stage[k].valid <= 1'b0;
        end else if (!stall_signal) begin
            r_stage[0] <= {in_valid, inputs};
            for (int k = 1; k < STAGES; k++) r_stage[k] <= r_stage[k-1];
        end
    end

    stall_pipe_fifo #(
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_flush (flush),
        .i_push  (w_push),
        .i_data  (r_stage[STAGES-1].data),
        .i_pop   (w_pop),
        .o_head  (resource_input),
        .o_count (occupancy),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A grant landing in a flush or reset cycle must never produce a result.
    assign w_resp_in = w_pop & ~flush & ~reset;

    generate
        if (RESP_LAT == 0) begin : g_resp_comb
            assign out_valid = w_resp_in;
        end else begin : g_resp_dly
            logic [RESP_LAT-1:0] r_resp;
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    r_resp <= '0;
                end else begin
                    r_resp[0] <= w_resp_in;
                    for (int i = 1; i < RESP_LAT; i++) r_resp[i] <= r_resp[i-1];
                end
            end
            assign out_valid = r_resp[RESP_LAT-1];
        end
    endgenerate

    assign outputs = out_valid ? resource_output : '0;

`ifdef STALL_PIPE_STATS_EN
    logic [31:0] r_stall_cycles;
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_stall_cycles <= '0;
        end else if (stall_signal && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end
    assign stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stall_pipe_arb.sv
// ============================================================================
// Module : tb_stall_pipe_arb
// Brief  : Directed bench for stall_pipe_arb (defaults, BUF_DEPTH=3, RESP_LAT=3).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stall_pipe_arb;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, grant;
    logic [31:0] din, rout;

    logic a_ready, a_req, a_ov, a_stall; logic [31:0] a_ri, a_out; logic [2:0] a_occ;
    logic b_ready, b_req, b_ov, b_stall; logic [31:0] b_ri, b_out; logic [1:0] b_occ;
    logic c_ready, c_req, c_ov, c_stall; logic [31:0] c_ri, c_out; logic [2:0] c_occ;
`ifdef STALL_PIPE_STATS_EN
    logic [31:0] a_sc, b_sc, c_sc;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stall_pipe_arb u_dut (
        .clk(clk), .reset(reset), .inputs(din), .in_valid(in_valid), .in_ready(a_ready),
        .flush(flush), .arbiter_grant(grant), .resource_output(rout), .arbiter_req(a_req),
        .resource_input(a_ri), .outputs(a_out), .out_valid(a_ov), .stall_signal(a_stall),
`ifdef STALL_PIPE_STATS_EN
        .stall_cycles(a_sc),
`endif
        .occupancy(a_occ)
    );

    stall_pipe_arb #(.BUF_DEPTH(3)) u_d3 (
        .clk(clk), .reset(reset), .inputs(din), .in_valid(in_valid), .in_ready(b_ready),
        .flush(flush), .arbiter_grant(grant), .resource_output(rout), .arbiter_req(b_req),
        .resource_input(b_ri), .outputs(b_out), .out_valid(b_ov), .stall_signal(b_stall),
`ifdef STALL_PIPE_STATS_EN
        .stall_cycles(b_sc),
`endif
        .occupancy(b_occ)
    );

    stall_pipe_arb #(.RESP_LAT(3)) u_l3 (
        .clk(clk), .reset(reset), .inputs(din), .in_valid(in_valid), .in_ready(c_ready),
        .flush(flush), .arbiter_grant(grant), .resource_output(rout), .arbiter_req(c_req),
        .resource_input(c_ri), .outputs(c_out), .out_valid(c_ov), .stall_signal(c_stall),
`ifdef STALL_PIPE_STATS_EN
        .stall_cycles(c_sc),
`endif
        .occupancy(c_occ)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; din = 0; flush = 0; grant = 0; rout = 32'h5555_0000;
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (a_req   !== 1'b0)  begin errors++; $display("FAIL rst_req got=%0h exp=0", a_req); end
        checks++; if (a_ov    !== 1'b0)  begin errors++; $display("FAIL rst_out_valid got=%0h exp=0", a_ov); end
        checks++; if (a_out   !== 32'h0) begin errors++; $display("FAIL rst_outputs got=%0h exp=0", a_out); end
        checks++; if (a_ri    !== 32'h0) begin errors++; $display("FAIL rst_res_in got=%0h exp=0", a_ri); end
        checks++; if (a_stall !== 1'b0)  begin errors++; $display("FAIL rst_stall got=%0h exp=0", a_stall); end
        checks++; if (a_ready !== 1'b1)  begin errors++; $display("FAIL rst_ready got=%0h exp=1", a_ready); end
        checks++; if (a_occ   !== 3'd0)  begin errors++; $display("FAIL rst_occ got=%0h exp=0", a_occ); end
        tick();
        // Three beats in flight, then a one-cycle reset.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; din = 32'h100 + i;
            tick();
        end
        in_valid = 0; reset = 1;
        tick();
        reset = 0;
        #1;
        checks++; if (a_occ   !== 3'd0) begin errors++; $display("FAIL mid_rst_occ got=%0h exp=0", a_occ); end
        checks++; if (a_req   !== 1'b0) begin errors++; $display("FAIL mid_rst_req got=%0h exp=0", a_req); end
        checks++; if (a_ov    !== 1'b0) begin errors++; $display("FAIL mid_rst_ov got=%0h exp=0", a_ov); end
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall got=%0h exp=0", a_stall); end
        repeat (3) tick();
        checks++; if (a_occ   !== 3'd0) begin errors++; $display("FAIL mid_rst_stage_clr got=%0h exp=0", a_occ); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_ri [8] = '{32'h0, 32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h0, 32'h0};
        logic        exp_ov [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] beat   [3] = '{32'h11, 32'h22, 32'h33};
        logic [31:0] e_out;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            grant    = 1;
            in_valid = (c < 3);
            din      = (c < 3) ? beat[c] : 32'h0;
            rout     = 32'hA0 + c;
            #1;
            e_out = exp_ov[c] ? (32'hA0 + c) : 32'h0;
            checks++; if (a_ri  !== exp_ri[c]) begin errors++; $display("FAIL stream_res_in c=%0d got=%0h exp=%0h", c, a_ri, exp_ri[c]); end
            checks++; if (a_ov  !== exp_ov[c]) begin errors++; $display("FAIL stream_ov c=%0d got=%0h exp=%0h", c, a_ov, exp_ov[c]); end
            checks++; if (a_out !== e_out)     begin errors++; $display("FAIL stream_out c=%0d got=%0h exp=%0h", c, a_out, e_out); end
            if (c == 3) begin
                checks++; if (a_occ !== 3'd1) begin errors++; $display("FAIL stream_occ got=%0h exp=1", a_occ); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        int b = 1;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            grant = 0; in_valid = (b <= 8); din = b;
            #1;
            checks++; if (a_ready !== (c < 6)) begin errors++; $display("FAIL bp_ready c=%0d got=%0h exp=%0h", c, a_ready, (c < 6)); end
            if (c >= 6) begin
                checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL bp_stall c=%0d got=%0h exp=1", c, a_stall); end
                checks++; if (a_occ !== 3'd4)   begin errors++; $display("FAIL bp_occ c=%0d got=%0h exp=4", c, a_occ); end
            end
            if (a_ready && in_valid) b++;
            tick();
        end
        for (int c = 0; c < 40 && got.size() < 8; c++) begin
            grant = 1; in_valid = (b <= 8); din = b;
            #1;
            if (c == 0) begin
                checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL bp_release_stall got=%0h exp=0", a_stall); end
                checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0h exp=1", a_ready); end
            end
            if (a_req) got.push_back(a_ri);
            if (a_ready && in_valid) b++;
            tick();
            if (c == 0) begin
                checks++; if (a_occ !== 3'd4) begin errors++; $display("FAIL bp_pushpop_occ got=%0h exp=4", a_occ); end
            end
        end
        checks++; if (got.size() != 8) begin errors++; $display("FAIL bp_count got=%0d exp=8", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== 32'(i + 1)) begin errors++; $display("FAIL bp_order i=%0d got=%0h exp=%0h", i, got[i], i + 1); end
        end
        in_valid = 0;
        repeat (4) tick();
        checks++; if (a_req !== 1'b0) begin errors++; $display("FAIL bp_drained_req got=%0h exp=0", a_req); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 11; c++) begin
            grant = 0; in_valid = 1; din = 32'h40 + c;
            #1;
            if (c == 6) begin
                checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL fl_full_stall got=%0h exp=1", a_stall); end
                checks++; if (a_occ !== 3'd4)   begin errors++; $display("FAIL fl_full_occ got=%0h exp=4", a_occ); end
            end
            tick();
        end
`ifdef STALL_PIPE_STATS_EN
        checks++; if (a_sc !== 32'd5) begin errors++; $display("FAIL stats_count got=%0d exp=5", a_sc); end
`endif
        flush = 1; grant = 1; in_valid = 0; rout = 32'hDEAD_BEEF;
        tick();
        flush = 0; grant = 0;
        #1;
        checks++; if (a_occ   !== 3'd0)  begin errors++; $display("FAIL fl_occ got=%0h exp=0", a_occ); end
        checks++; if (a_ov    !== 1'b0)  begin errors++; $display("FAIL fl_ov got=%0h exp=0", a_ov); end
        checks++; if (a_out   !== 32'h0) begin errors++; $display("FAIL fl_out got=%0h exp=0", a_out); end
        checks++; if (a_req   !== 1'b0)  begin errors++; $display("FAIL fl_req got=%0h exp=0", a_req); end
        checks++; if (a_ready !== 1'b1)  begin errors++; $display("FAIL fl_ready got=%0h exp=1", a_ready); end
`ifdef STALL_PIPE_STATS_EN
        checks++; if (a_sc !== 32'd0) begin errors++; $display("FAIL stats_flush got=%0d exp=0", a_sc); end
`endif
        repeat (3) tick();
        checks++; if (a_occ !== 3'd0) begin errors++; $display("FAIL fl_stage_clr got=%0h exp=0", a_occ); end
    endtask

    task automatic test_wrap();
        logic [31:0] got[$];
        int b = 0;
        do_reset();
        for (int c = 0; c < 100 && got.size() < 10; c++) begin
            grant = c[0]; in_valid = (b < 10); din = 32'h60 + b;
            #1;
            if (b_req && grant) got.push_back(b_ri);
            if (b_ready && in_valid) b++;
            tick();
        end
        checks++; if (got.size() != 10) begin errors++; $display("FAIL wrap_count got=%0d exp=10", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== 32'(32'h60 + i)) begin errors++; $display("FAIL wrap_order i=%0d got=%0h exp=%0h", i, got[i], 32'h60 + i); end
        end
    endtask

    task automatic test_resp_lat();
        logic [31:0] e_out;
        do_reset();
        in_valid = 1; din = 32'h77;
        tick();
        in_valid = 0;
        tick();
        tick();
        for (int c = 3; c < 10; c++) begin
            grant = (c == 3); rout = 32'hB0 + c;
            #1;
            if (c == 3) begin
                checks++; if (c_req !== 1'b1)  begin errors++; $display("FAIL lat_req got=%0h exp=1", c_req); end
                checks++; if (c_ri !== 32'h77) begin errors++; $display("FAIL lat_res_in got=%0h exp=77", c_ri); end
            end
            e_out = (c == 6) ? (32'hB0 + c) : 32'h0;
            checks++; if (c_ov !== (c == 6)) begin errors++; $display("FAIL lat_ov c=%0d got=%0h exp=%0h", c, c_ov, (c == 6)); end
            checks++; if (c_out !== e_out)   begin errors++; $display("FAIL lat_out c=%0d got=%0h exp=%0h", c, c_out, e_out); end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_wrap();
        test_resp_lat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
